// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : request/grant/read-return bundle for the I2C and host
//                       ports plus the registered RAM port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              i2c_req;
  logic              i2c_we;
  logic [ADDR_W-1:0] i2c_addr;
  logic [DATA_W-1:0] i2c_wdata;
  logic              i2c_gnt;
  logic              i2c_rvalid;
  logic [DATA_W-1:0] i2c_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and RAM model side
  modport master (
    output i2c_req, i2c_we, i2c_addr, i2c_wdata,
    input  i2c_gnt, i2c_rvalid, i2c_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_wdata, mem_wren,
    output mem_rdata
  );

  // Arbiter side
  modport slave (
    input  i2c_req, i2c_we, i2c_addr, i2c_wdata,
    output i2c_gnt, i2c_rvalid, i2c_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_wdata, mem_wren,
    input  mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : single-port RAM arbiter, I2C priority with bounded host
//                    starvation, registered RAM drive and held read data
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int              CNT_W      = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACC_I2C  = 2'd1,
    ACC_HOST = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_wren;
  logic              r_rd_pend_i2c;
  logic              r_rd_pend_host;
  logic [DATA_W-1:0] r_hold_i2c;
  logic [DATA_W-1:0] r_hold_host;
  logic              w_host_prio;

  // Next-state and grant decode
  always_comb begin
    w_next       = r_state;
    w_host_prio  = bus.host_req && (r_wait_cnt == C_MAX_WAIT);
    bus.i2c_gnt  = 1'b0;
    bus.host_gnt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i2c_req && !w_host_prio) begin
          w_next = ACC_I2C;
        end else if (bus.host_req) begin
          w_next = ACC_HOST;
        end
      end
      ACC_I2C: begin
        bus.i2c_gnt = 1'b1;
        w_next      = IDLE;
      end
      ACC_HOST: begin
        bus.host_gnt = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_wait_cnt     <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_wren     <= 1'b0;
      r_rd_pend_i2c  <= 1'b0;
      r_rd_pend_host <= 1'b0;
      r_hold_i2c     <= '0;
      r_hold_host    <= '0;
    end else begin
      r_state <= w_next;

      if (!bus.host_req || (r_state == IDLE && w_next == ACC_HOST)) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != C_MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end

      // RAM drive is loaded only on entry to an access; wren lasts one cycle
      if (r_state == IDLE && w_next == ACC_I2C) begin
        r_mem_addr  <= bus.i2c_addr;
        r_mem_wdata <= bus.i2c_wdata;
        r_mem_wren  <= bus.i2c_we;
      end else if (r_state == IDLE && w_next == ACC_HOST) begin
        r_mem_addr  <= bus.host_addr;
        r_mem_wdata <= bus.host_wdata;
        r_mem_wren  <= bus.host_we;
      end else begin
        r_mem_wren  <= 1'b0;
      end

      r_rd_pend_i2c  <= (r_state == ACC_I2C)  && !r_mem_wren;
      r_rd_pend_host <= (r_state == ACC_HOST) && !r_mem_wren;

      if (r_rd_pend_i2c) begin
        r_hold_i2c <= bus.mem_rdata;
      end
      if (r_rd_pend_host) begin
        r_hold_host <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.mem_wren    = r_mem_wren;
  assign bus.i2c_rvalid  = r_rd_pend_i2c;
  assign bus.host_rvalid = r_rd_pend_host;
  assign bus.i2c_rdata   = r_rd_pend_i2c  ? bus.mem_rdata : r_hold_i2c;
  assign bus.host_rdata  = r_rd_pend_host ? bus.mem_rdata : r_hold_host;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed scenarios plus randomized traffic checked
//                       against a transaction-level arbitration/memory model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(8), .HOST_MAX_WAIT(MAXW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Synchronous RAM: read data one cycle after address
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: expected outputs for the current cycle plus memory image
  logic [7:0] shadow [256];
  bit         e_ig, e_hg, e_wren, e_irv, e_hrv;
  logic [7:0] e_addr, e_wd, e_ird, e_hrd;
  int         m_wait;
  logic [7:0] m_rd_i, m_rd_h, m_hold_i, m_hold_h;

  task automatic model_reset();
    e_ig = 0; e_hg = 0; e_wren = 0; e_irv = 0; e_hrv = 0;
    e_addr = 0; e_wd = 0; e_ird = 0; e_hrd = 0;
    m_wait = 0; m_rd_i = 0; m_rd_h = 0; m_hold_i = 0; m_hold_h = 0;
  endtask

  // Advance the model one clock using the inputs now applied
  task automatic predict();
    bit busy, n_irv, n_hrv, gi, gh;
    busy  = e_ig || e_hg;
    n_irv = e_ig && !e_wren;
    n_hrv = e_hg && !e_wren;
    if (e_irv) m_hold_i = e_ird;
    if (e_hrv) m_hold_h = e_hrd;
    e_irv = n_irv;
    e_hrv = n_hrv;
    e_ird = n_irv ? m_rd_i : m_hold_i;
    e_hrd = n_hrv ? m_rd_h : m_hold_h;
    gi = 0; gh = 0;
    if (!busy) begin
      if (bus.i2c_req && !(bus.host_req && m_wait >= MAXW)) gi = 1;
      else if (bus.host_req) gh = 1;
    end
    if (!bus.host_req || gh) m_wait = 0;
    else if (m_wait < MAXW) m_wait++;
    e_ig = gi; e_hg = gh; e_wren = 0;
    if (gi) begin
      e_addr = bus.i2c_addr; e_wd = bus.i2c_wdata; e_wren = bus.i2c_we;
      if (bus.i2c_we) shadow[bus.i2c_addr] = bus.i2c_wdata;
      else m_rd_i = shadow[bus.i2c_addr];
    end
    if (gh) begin
      e_addr = bus.host_addr; e_wd = bus.host_wdata; e_wren = bus.host_we;
      if (bus.host_we) shadow[bus.host_addr] = bus.host_wdata;
      else m_rd_h = shadow[bus.host_addr];
    end
  endtask

  task automatic step(input bit auto_drop);
    predict();
    @(posedge clk);
    @(negedge clk);
    chk("i2c_gnt",     32'(bus.i2c_gnt),     32'(e_ig));
    chk("host_gnt",    32'(bus.host_gnt),    32'(e_hg));
    chk("mem_wren",    32'(bus.mem_wren),    32'(e_wren));
    chk("mem_addr",    32'(bus.mem_addr),    32'(e_addr));
    chk("mem_wdata",   32'(bus.mem_wdata),   32'(e_wd));
    chk("i2c_rvalid",  32'(bus.i2c_rvalid),  32'(e_irv));
    chk("host_rvalid", 32'(bus.host_rvalid), 32'(e_hrv));
    chk("i2c_rdata",   32'(bus.i2c_rdata),   32'(e_ird));
    chk("host_rdata",  32'(bus.host_rdata),  32'(e_hrd));
    if (auto_drop) begin
      if (e_ig) bus.i2c_req  = 1'b0;
      if (e_hg) bus.host_req = 1'b0;
    end
  endtask

  task automatic set_req(input bit port, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (port) begin
      bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    end else begin
      bus.i2c_req = 1'b1; bus.i2c_we = we; bus.i2c_addr = a; bus.i2c_wdata = d;
    end
  endtask

  // Returns at the falling edge inside the grant cycle
  task automatic access(input bit port, input bit we, input logic [7:0] a, input logic [7:0] d);
    set_req(port, we, a, d);
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (port ? e_hg : e_ig) return;
    end
    chk("grant_timeout", 32'd0, 32'd1);
    bus.i2c_req = 1'b0; bus.host_req = 1'b0;
  endtask

  initial begin
    bit p_i, p_h, busy_now;
    rst_n = 1'b0;
    bus.i2c_req = 0; bus.i2c_we = 0; bus.i2c_addr = 0; bus.i2c_wdata = 0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_i2c_gnt",  32'(bus.i2c_gnt),   32'd0);
    chk("reset_host_gnt", 32'(bus.host_gnt),  32'd0);
    chk("reset_mem_wren", 32'(bus.mem_wren),  32'd0);
    chk("reset_mem_addr", 32'(bus.mem_addr),  32'd0);
    chk("reset_i2c_rdata",32'(bus.i2c_rdata), 32'd0);
    rst_n = 1'b1;
    step(1);

    // 1: I2C write then read back
    access(0, 1, 8'h10, 8'hA5);
    chk("t1_wren",  32'(bus.mem_wren),  32'd1);
    chk("t1_addr",  32'(bus.mem_addr),  32'h10);
    chk("t1_wdata", 32'(bus.mem_wdata), 32'hA5);
    access(0, 0, 8'h10, 8'h00);
    step(1);
    chk("t1_rvalid", 32'(bus.i2c_rvalid), 32'd1);
    chk("t1_rdata",  32'(bus.i2c_rdata),  32'hA5);
    step(1);
    chk("t1_hold",   32'(bus.i2c_rdata),  32'hA5);

    // 2: host write then read; I2C side untouched
    access(1, 1, 8'h20, 8'h3C);
    access(1, 0, 8'h20, 8'h00);
    step(1);
    chk("t2_rvalid",   32'(bus.host_rvalid), 32'd1);
    chk("t2_rdata",    32'(bus.host_rdata),  32'h3C);
    chk("t2_i2c_rv",   32'(bus.i2c_rvalid),  32'd0);
    chk("t2_i2c_data", 32'(bus.i2c_rdata),   32'hA5);
    repeat (2) step(1);

    // 3: both held; pattern I2C, -, I2C, -, HOST, - repeating
    set_req(0, 0, 8'h10, 8'h00);
    set_req(1, 0, 8'h20, 8'h00);
    for (int k = 0; k < 12; k++) begin
      step(0);
      chk("t3_i2c_gnt",  32'(bus.i2c_gnt),  32'((k % 6 == 0) || (k % 6 == 2)));
      chk("t3_host_gnt", 32'(bus.host_gnt), 32'(k % 6 == 4));
    end
    bus.i2c_req = 0; bus.host_req = 0;
    repeat (3) step(1);

    // 4: cross-port read isolation
    access(0, 1, 8'h50, 8'h11);
    access(1, 1, 8'h51, 8'h22);
    step(1);
    set_req(0, 0, 8'h50, 8'h00);
    set_req(1, 0, 8'h51, 8'h00);
    for (int k = 0; k < 20 && (bus.i2c_req || bus.host_req); k++) step(1);
    repeat (3) step(1);
    chk("t4_i2c_hold",  32'(bus.i2c_rdata),  32'h11);
    chk("t4_host_hold", 32'(bus.host_rdata), 32'h22);

    // 5: reset during an I2C read grant
    access(0, 0, 8'h10, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("t5_gnt",    32'(bus.i2c_gnt),    32'd0);
    chk("t5_wren",   32'(bus.mem_wren),   32'd0);
    chk("t5_addr",   32'(bus.mem_addr),   32'd0);
    chk("t5_rdata",  32'(bus.i2c_rdata),  32'd0);
    chk("t5_hrdata", 32'(bus.host_rdata), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("t5_no_rvalid", 32'(bus.i2c_rvalid), 32'd0);
    end
    access(0, 0, 8'h10, 8'h00);
    step(1);
    chk("t5_reread", 32'(bus.i2c_rdata), 32'hA5);

    // 6: request pulsed only during an access is never served
    access(1, 1, 8'h40, 8'h77);
    set_req(0, 1, 8'h40, 8'hEE);
    step(1);
    chk("t6_no_gnt", 32'(bus.i2c_gnt), 32'd0);
    bus.i2c_req = 1'b0;
    step(1);
    chk("t6_no_gnt2", 32'(bus.i2c_gnt),  32'd0);
    chk("t6_no_wren", 32'(bus.mem_wren), 32'd0);
    access(1, 0, 8'h40, 8'h00);
    step(1);
    chk("t6_data", 32'(bus.host_rdata), 32'h77);

    // Preload every address, then randomized traffic
    for (int i = 0; i < 256; i++) access(i[0], 1, 8'(i), 8'($urandom));
    step(1);
    p_i = 0; p_h = 0;
    for (int c = 0; c < 2000; c++) begin
      step(1);
      busy_now = e_ig || e_hg;
      if (p_i) begin
        bus.i2c_req = 0; p_i = 0;
      end else if (!bus.i2c_req) begin
        if (busy_now && $urandom_range(0, 3) == 0) begin
          set_req(0, 1'($urandom), 8'($urandom), 8'($urandom)); p_i = 1;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        end
      end
      if (p_h) begin
        bus.host_req = 0; p_h = 0;
      end else if (!bus.host_req) begin
        if (busy_now && $urandom_range(0, 3) == 0) begin
          set_req(1, 1'($urandom), 8'($urandom), 8'($urandom)); p_h = 1;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        end
      end
    end
    bus.i2c_req = 0; bus.host_req = 0;
    repeat (4) step(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
